// File: rtl/display_pkg.sv
// display_pkg: shared constants, state encoding and clamp helper for the display scheduler
package display_pkg;
  localparam logic [13:0] DISP_MAX = 14'd9999;
  localparam int N_SRC = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, PRIO = 2'd2} state_t;
  function automatic logic [13:0] clamp14(input logic [13:0] v);
    return (v > DISP_MAX) ? DISP_MAX : v;
  endfunction
endpackage

// File: rtl/rr_next4.sv
// rr_next4: next set mask index after start, wrapping, with start itself as last candidate
module rr_next4 (
  input  logic [3:0] mask,
  input  logic [1:0] start,
  output logic [1:0] idx,
  output logic       found
);
  // walk offsets from farthest to nearest so the nearest set index wins
  always_comb begin
    found = |mask;
    idx = start;
    for (int k = 3; k >= 1; k--)
      if (mask[start + 2'(k)]) idx = start + 2'(k);
  end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: rotates and preempts four value sources onto one clamped display value
module display_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] pri,
  input  logic             hold,
  input  logic [13:0]      val0,
  input  logic [13:0]      val1,
  input  logic [13:0]      val2,
  input  logic [13:0]      val3,
  output logic [13:0]      disp_value,
  output logic [N_SRC-1:0] grant,
  output logic             sat,
  output logic             switch_pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);
  state_t state, state_nxt;
  logic [1:0] g, g_nxt, p, p_nxt, rr_start, ri, pi, idx_nxt;
  logic rf, pf, active;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_SRC-1:0] elig, grant_nxt;
  logic [13:0] v_sel;
  assign elig = pri & req;
  assign rr_start = (state == IDLE) ? 2'd3 : (state == PRIO) ? g - 2'd1 : g;
  rr_next4 u_rr (.mask(req), .start(rr_start), .idx(ri), .found(rf));
  rr_next4 u_pri (.mask(elig), .start(2'd3), .idx(pi), .found(pf));
  // next-state: idle entry, show rotation rules in priority order, priority hold/resume
  always_comb begin
    state_nxt = state;
    g_nxt = g;
    p_nxt = p;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pf) begin
          state_nxt = PRIO;
          p_nxt = pi;
        end else if (rf) begin
          state_nxt = SHOW;
          g_nxt = ri;
        end
      end
      SHOW: begin
        if (pf) begin
          state_nxt = PRIO;
          p_nxt = pi;
        end else if (!req[g]) begin
          cnt_nxt = '0;
          if (rf) g_nxt = ri;
          else state_nxt = IDLE;
        end else if (cnt == LAST && !hold) begin
          g_nxt = ri;
          cnt_nxt = '0;
        end else if (!hold) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRIO: begin
        if (pf) begin
          p_nxt = pi;
        end else begin
          cnt_nxt = '0;
          state_nxt = rf ? SHOW : IDLE;
          if (rf) g_nxt = ri;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign active = state_nxt != IDLE;
  assign idx_nxt = (state_nxt == PRIO) ? p_nxt : g_nxt;
  assign grant_nxt = active ? 4'(1) << idx_nxt : '0;
  assign v_sel = idx_nxt[1] ? (idx_nxt[0] ? val3 : val2) : (idx_nxt[0] ? val1 : val0);
  // state and registered outputs; display value follows the source granted this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      p <= '0;
      cnt <= '0;
      grant <= '0;
      disp_value <= '0;
      sat <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      g <= g_nxt;
      p <= p_nxt;
      cnt <= cnt_nxt;
      grant <= grant_nxt;
      disp_value <= active ? clamp14(v_sel) : '0;
      sat <= active && (v_sel > DISP_MAX);
      switch_pulse <= (grant_nxt != '0) && (grant_nxt != grant);
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of rotation, clamp, priority, hold and async reset
module tb_display_scheduler;
  logic clk = 0, rst_n = 0, hold = 0;
  logic [3:0] req = 0, pri = 0, grant;
  logic [13:0] val0 = 0, val1 = 0, val2 = 0, val3 = 0, disp_value;
  logic sat, switch_pulse;
  int checks = 0, errors = 0;
  display_scheduler #(.DWELL_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pri(pri), .hold(hold),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .disp_value(disp_value), .grant(grant), .sat(sat), .switch_pulse(switch_pulse)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [13:0] d, input logic s, input logic sp);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".disp"}, 32'(disp_value), 32'(d));
    chk({tag, ".sat"}, 32'(sat), 32'(s));
    chk({tag, ".pulse"}, 32'(switch_pulse), 32'(sp));
  endtask
  initial begin
    req = 4'b1111;
    val0 = 14'd12; val1 = 14'd12000; val2 = 14'd345; val3 = 14'd7;
    step(); step();
    chk_out("reset", 4'b0000, 14'd0, 1'b0, 1'b0);
    rst_n = 1; req = 4'b0000;
    step();
    chk_out("idle", 4'b0000, 14'd0, 1'b0, 1'b0);
    req = 4'b0101;
    step();
    chk_out("rr_first", 4'b0001, 14'd12, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("rr_dwell0", 4'b0001, 14'd12, 1'b0, 1'b0);
    end
    step();
    chk_out("rr_to2", 4'b0100, 14'd345, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk_out("rr_dwell2", 4'b0100, 14'd345, 1'b0, 1'b0);
    step();
    chk_out("rr_back0", 4'b0001, 14'd12, 1'b0, 1'b1);
    req = 4'b0010;
    step();
    chk_out("clamp", 4'b0010, 14'd9999, 1'b1, 1'b1);
    val1 = 14'd42;
    step();
    chk_out("live_val", 4'b0010, 14'd42, 1'b0, 1'b0);
    req = 4'b0011;
    step(); step(); step();
    chk_out("rot_to0", 4'b0001, 14'd12, 1'b0, 1'b1);
    step(); step();
    pri = 4'b1000; req = 4'b1011;
    step();
    chk_out("prio3", 4'b1000, 14'd7, 1'b0, 1'b1);
    pri = 4'b1100; req = 4'b1111;
    step();
    chk_out("prio2", 4'b0100, 14'd345, 1'b0, 1'b1);
    pri = 4'b0000; req = 4'b0011;
    step();
    chk_out("resume", 4'b0001, 14'd12, 1'b0, 1'b1);
    step(); step(); step();
    chk_out("fresh_dwell", 4'b0001, 14'd12, 1'b0, 1'b0);
    step();
    chk_out("after_resume", 4'b0010, 14'd42, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk_out("pre_hold", 4'b0001, 14'd12, 1'b0, 1'b1);
    hold = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold.grant", 32'(grant), 32'(4'b0001));
    end
    req = 4'b0010;
    step();
    chk_out("hold_drop", 4'b0010, 14'd42, 1'b0, 1'b1);
    hold = 0;
    pri = 4'b0001; req = 4'b0011;
    step();
    chk_out("prio_again", 4'b0001, 14'd12, 1'b0, 1'b1);
    #2 rst_n = 0;
    #1;
    chk_out("async_rst", 4'b0000, 14'd0, 1'b0, 1'b0);
    #1 rst_n = 1;
    step();
    chk_out("restart", 4'b0001, 14'd12, 1'b0, 1'b1);
    pri = 4'b0000; req = 4'b0000;
    step();
    chk_out("to_idle", 4'b0000, 14'd0, 1'b0, 1'b0);
    req = 4'b0100; val2 = 14'd9999;
    step();
    chk_out("single_max", 4'b0100, 14'd9999, 1'b0, 1'b1);
    val2 = 14'd10000;
    step();
    chk_out("single_sat", 4'b0100, 14'd9999, 1'b1, 1'b0);
    step(); step();
    val2 = 14'd0;
    step();
    chk_out("single_rot", 4'b0100, 14'd0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the single 4-digit 7-segment display among four value sources: stopwatch, lap, counter and diagnostic.
- Picks which source is shown and rotates between active sources on a dwell timer.
- Lets a priority request preempt the rotation.
- Clamps the selected value to the 0-9999 range and drives the `value` input of `display_controller`.

Parameters:
- DWELL_CYCLES, 50_000_000, clock cycles each source is shown before rotating (1 s at 50 MHz).
- CNT_W, 26, width of the dwell counter; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  req[i]=1: source i has a value to display.
- pri  in  4  pri[i]=1: source i demands immediate display; ignored unless req[i]=1.
- hold  in  1  freezes the dwell counter; no timed rotation while high.
- val0..val3  in  14 each  source values, unsigned.
- disp_value  out  14  value to `display_controller`; always ≤ 9999.
- grant  out  4  one-hot index of the displayed source; 0 when idle.
- sat  out  1  high when the granted value was >9999 and has been clamped.
- switch_pulse  out  1  one-cycle pulse on the cycle `grant` changes to a different nonzero source.

Behaviour:
- All outputs are registered.
- Reset values: disp_value=0, grant=0, sat=0, switch_pulse=0, state=IDLE, rr pointer g=0, dwell counter=0.
- Reset acts immediately and asynchronously, including mid-dwell or mid-PRIO.
- Latency: a req/pri change is reflected in grant on the next rising edge.
- disp_value/sat track the live val[grant] with 1-cycle latency, including value changes mid-dwell.
- Clamp rule: v>9999 gives disp_value=9999, sat=1; otherwise disp_value=v, sat=0.
- States:
  - IDLE: grant=0, disp_value=0, sat=0.
    - Any req goes to SHOW with g = lowest set req index, counter=0.
    - Any eligible pri (pri&req) goes to PRIO instead.
  - SHOW (grant = onehot(g)), checked in priority order:
    - (a) any pri&req != 0: go to PRIO with p = lowest set index. g is saved. Counter is frozen.
    - (b) req[g]=0: g = next set req index after g (wrapping 3→0), counter=0. If no req remains, go to IDLE.
    - (c) counter==DWELL_CYCLES-1 and hold=0: g = next set req index after g, wrapping, with g itself as the last candidate. Counter=0.
    - (d) otherwise counter += 1 unless hold=1.
  - PRIO (grant = onehot(p)):
    - A lower-index eligible pri preempts: p updates immediately.
    - pri[p]&req[p] dropping while another eligible pri exists: p = lowest such index.
    - No eligible pri left: return to SHOW. Resume g if req[g]=1, else next set req after g. Counter=0.
    - If req is all zero: go to IDLE.
- Round-robin search examines indices g+1, g+2, g+3, g (mod 4).
- With a single requester, rotation re-selects it: counter restarts, grant unchanged, no switch_pulse.
- switch_pulse=1 only when the new grant is nonzero and differs from the old grant. This includes the IDLE→source transition.
- hold has no effect on (a), (b) or PRIO transitions.
- A req drop and a dwell expiry in the same cycle are handled by rule (b): one rotation only.

Decomposition:
- Shared package display_pkg holds:
  - DISP_MAX = 14'd9999;
  - N_SRC = 4;
  - state encoding IDLE=2'd0, SHOW=2'd1, PRIO=2'd2.
- One sub-module, rr_next4: combinational. Inputs are a 4-bit request mask and a 2-bit start index. Outputs are the next set index after start (wrapping, start last) and a found flag. It is used for both rotation and resume.

Test Plan (DWELL_CYCLES=4):
- Reset and idle: rst_n low with req=4'b1111 → all outputs 0. Release, req=4'b0000 → grant stays 0, disp_value=0.
- Round robin: req=4'b0101, val0=12, val2=345 → grant=0001 with disp_value=12. After 4 cycles grant=0100 with disp_value=345 and one switch_pulse. After 4 more cycles grant=0001.
- Clamp and live tracking: grant on source 1 with val1=12000 → disp_value=9999, sat=1. Change val1 to 42 → next cycle disp_value=42, sat=0.
- Priority preempt and resume: rotating 0/1, grant=0001 at counter=2, raise pri[3]&req[3] → next cycle grant=1000. Raise pri[2] → grant=0100. Drop both → grant=0001 with a fresh 4-cycle dwell.
- Hold and req drop: hold=1 with req=4'b0011 → grant stays 0001 for 20 cycles. Drop req[0] → next cycle grant=0010, switch_pulse=1.
- Async reset mid-PRIO: assert rst_n low between clock edges → outputs are 0 immediately, without waiting for a clock edge. After release the scheduler restarts from IDLE.
